// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S transmit path.
package i2s_pkg;

    localparam int unsigned I2S_DATA_W     = 32;
    localparam int unsigned I2S_FIFO_DEPTH = 8;

    typedef logic [I2S_DATA_W-1:0] i2s_word_t;

endpackage

// File: rtl/i2s_fifo_mem.sv
// Storage for the I2S Tx FIFO: one write port and one registered read port.
// Only the read register is reset or cleared; the array itself holds no reset.
module i2s_fifo_mem
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W = I2S_DATA_W,
    parameter int unsigned DEPTH  = I2S_FIFO_DEPTH
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge pclk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            rd_data_q <= '0;
        end else if (clear) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/i2s_tx_fifo.sv
// Word FIFO between the APB Tx data handshake and the I2S serializer.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags with err_clr.
module i2s_tx_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W    = I2S_DATA_W,
    parameter int unsigned DEPTH     = I2S_FIFO_DEPTH,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic                   pclk,
    input  logic                   preset,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
`ifdef FIFO_ERR_FLAGS_EN
    input  logic                   err_clr,
    output logic                   ovf,
    output logic                   unf,
`endif
    output logic [DATA_W-1:0]      rd_data,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t level_q, level_d;
    logic full_q, full_d;
    logic empty_q, empty_d;
    logic afull_q, afull_d;
    logic aempty_q, aempty_d;
    logic wr_ok, rd_ok;

    // A full FIFO is never empty, so a read alongside a write always frees the slot.
    always_comb begin
        rd_ok    = rd_en && !empty_q;
        wr_ok    = wr_en && (!full_q || rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
        end
    end

    always_comb begin
        full_d   = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        level_d  = wr_ptr_d - rd_ptr_d;
        afull_d  = (level_d >= PW'(AFULL_TH));
        aempty_d = (level_d <= PW'(AEMPTY_TH));
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    i2s_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .pclk    (pclk),
        .preset  (preset),
        .clear   (flush),
        .wr_en   (wr_ok && !flush),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_ok && !flush),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (rd_data)
    );

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign level        = level_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, unf_q;
    logic ovf_set, unf_set;

    // A write paired with a read while full is accepted, so it is not an overflow.
    assign ovf_set = !flush && wr_en && full_q && !rd_en;
    assign unf_set = !flush && rd_en && empty_q;

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (err_clr) begin
                ovf_q <= 1'b0;
            end
            if (unf_set) begin
                unf_q <= 1'b1;
            end else if (err_clr) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`endif

endmodule
